hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Its `hi` output feeds the HI-select input of the register-writeback mux, in the slot the ALU high word occupies today. While an operation runs it asserts `busy`; the control unit uses `busy` to hold the PC and suppress register writes, so MFHI/MFLO after a multiply or divide read final values.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `clk`  in  1: core clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  3: operation code. 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `a`  in  WIDTH: rs value (multiplicand, dividend, or MT source).
- `b`  in  WIDTH: rt value (multiplier or divisor).
- `busy`  out  1: high while a mul/div is in flight.
- `done`  out  1: one-cycle pulse; `hi`/`lo` hold the new result.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE with `start`=1 and op MTHI/MTLO:
  - `hi` (or `lo`) loads `a` at that edge.
  - The FSM stays in IDLE; no `busy`, no `done`.
- IDLE with `start`=1 and a mul/div op:
  - Latch the op and the signs of `a` and `b`.
  - Load |a| and |b| for signed ops, or raw values for unsigned ops.
  - Clear the iteration counter and go to RUN.
- RUN executes WIDTH iterations, one per cycle, then moves to FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle.
- FIX runs for one cycle, then the FSM returns to IDLE. In FIX:
  - Apply two's-complement sign correction.
  - Write `hi`/`lo`.
  - Register `done`=1 for the following cycle.
- Multiply result: `hi`={upper word}, `lo`={lower word}. For MULT, negate the 2·WIDTH product when sign(a)≠sign(b).
- Divide result: `lo`=quotient, `hi`=remainder.
  - Quotient is negated when sign(a)≠sign(b).
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU), full latency: `lo`=all ones, `hi`=`a`, no sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. No trap.
- `hi`/`lo` keep their previous values until the FIX edge; partial results are never visible.
- `start` while busy (RUN or FIX): ignored, with no queueing.
- Operands are sampled only at acceptance; later changes to `a`/`b` have no effect.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0. Internal accumulators and counter are also cleared.
- Mul/div accepted at edge E0:
  - `busy` is high in the cycles after E0 through E0+WIDTH+1, which is 33 cycles for WIDTH=32.
  - `hi`/`lo` update at edge E0+WIDTH+1.
  - `done`=1 and `busy`=0 in the cycle after that edge.
- A new `start` is accepted in the same cycle `done` is high, because the FSM is already in IDLE.
- MTHI/MTLO have zero added latency: the value is visible the cycle after the edge.
- `rst_n` low mid-operation: immediate return to reset values. The operation is abandoned, no `done` is produced, and prior HI/LO are lost.
- `busy` and `done` come straight from registered state; no combinational path from `start`.

## Structure
- Shared package `hilo_pkg`, containing:
  - op encodings as localparams `OP_MULTU`…`OP_MTLO`;
  - the FSM state encoding;
  - `ITER_W` = clog2(WIDTH+1) for the counter.
- The control decoder imports the same op encodings.
- No sub-module. The FSM, the 2·WIDTH accumulator and the shared WIDTH+1 adder/subtractor live in one module of about 200 lines.

## Test plan
- MULTU a=0xFFFFFFFF, b=2 → `done` 34 cycles after the `start` cycle; `hi`=0x00000001, `lo`=0xFFFFFFFE; `busy` high exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB (−21).
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU a=5, b=0 → full latency, `lo`=0xFFFFFFFF, `hi`=0x00000005.
- MTHI a=0x1234 → `hi`=0x1234 next cycle, `busy` stays 0. Then MULTU 3×4 with `start` pulses and new operands during RUN → those pulses are ignored; result `hi`=0, `lo`=12; `hi` holds 0x1234 until the FIX edge.
- MULTU started, `rst_n` pulsed low at cycle 10 → `busy`=0, `hi`=`lo`=0 at once; no `done` ever follows.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states,
// iteration counter sizing. Also imported by the core's control decoder.
package hilo_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ITER_W    = $clog2(WIDTH_DEF + 1);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam int         OP_DIV_I = 3;
  localparam logic [2:0] OP_DIV   = 3'(OP_DIV_I);
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Counter width for a given operand width.
  function automatic int iter_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the core control/datapath and hilo_muldiv.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide with architectural HI/LO. One shared WIDTH+1
// adder/subtractor serves both shift-add multiply and restoring divide;
// operands are reduced to magnitudes at acceptance and signs fixed up in FIX.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_muldiv_if.slave  bus
);

  localparam int CW = iter_w(WIDTH);

  state_t             state, state_nxt;
  logic [1:0]         op_q;      // [1]=divide, [0]=signed
  logic               sa_q, sb_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept_md;
  logic               last_iter;
  logic               is_div;
  logic [WIDTH:0]     add_x, add_y;
  logic [WIDTH+1:0]   add_s;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Magnitude of an operand when the op is signed, raw value otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign accept_md = (state == S_IDLE) && bus.start && !bus.op[2];
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign is_div    = op_q[1];

  // Shared adder: add multiplicand for multiply, trial-subtract divisor for divide.
  always_comb begin
    add_x = is_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y = is_div ? ~{1'b0, opb} : {1'b0, opb};
    add_s = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};
  end

  // One iteration step; for divide, add_s carry-out set means no borrow.
  always_comb begin
    acc_nxt = acc;
    if (is_div) begin
      if (add_s[WIDTH+1]) acc_nxt = {add_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_nxt = {add_s[WIDTH:0], acc[WIDTH-1:1]};
      else        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Sign correction; divide-by-zero keeps all-ones quotient and hi = dividend.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic               neg_q;
    neg_q  = op_q[0] && (sa_q ^ sb_q);
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (opb == '0)  res_lo = '1;
      else if (neg_q) res_lo = -acc[WIDTH-1:0];
      else            res_lo = acc[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: IDLE -> RUN for WIDTH cycles -> FIX for one cycle -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_md) state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO writes and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              OP_MULTU, OP_MULT: begin
                op_q <= bus.op[1:0];
                sa_q <= bus.op[0] & bus.a[WIDTH-1];
                sb_q <= bus.op[0] & bus.b[WIDTH-1];
                acc  <= {{WIDTH{1'b0}}, mag(bus.b, bus.op[0])};
                opb  <= mag(bus.a, bus.op[0]);
                cnt  <= '0;
              end
              OP_DIVU, OP_DIV: begin
                op_q <= bus.op[1:0];
                sa_q <= bus.op[0] & bus.a[WIDTH-1];
                sb_q <= bus.op[0] & bus.b[WIDTH-1];
                acc  <= {{WIDTH{1'b0}}, mag(bus.a, bus.op[0])};
                opb  <= mag(bus.b, bus.op[0]);
                cnt  <= '0;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: hand-computed results, latency and busy
// width, MT ops, ignored start while busy, and mid-operation reset.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat, bcnt;
  logic hold_ok, done_seen;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
  endtask

  // Issue and wait for done; lat counts cycles from the start cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    issue(o, av, bv);
    lat  = 1;
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) break;
      if (bus.busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(bus.busy), 0);
    chk("rst_done", W'(bus.done), 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_lat", W'(lat), 34);
    chk("multu_busy_cycles", W'(bcnt), 33);
    chk("multu_busy_at_done", W'(bus.busy), 0);
    chk("multu_hi", bus.hi, 32'h0000_0001);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // Accepted in the done cycle.
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_lat", W'(lat), 34);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mult_m1m1_hi", bus.hi, 32'h0);
    chk("mult_m1m1_lo", bus.lo, 32'h1);

    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    chk("mult_min_hi", bus.hi, 32'h4000_0000);
    chk("mult_min_lo", bus.lo, 32'h0);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'h0);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    chk("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_7_m2_hi", bus.hi, 32'h1);

    run_op(OP_DIVU, 32'd100, 32'd7);
    chk("divu_100_7_lo", bus.lo, 32'd14);
    chk("divu_100_7_hi", bus.hi, 32'd2);

    run_op(OP_DIVU, 32'd5, 32'd0);
    chk("divu_z_lat", W'(lat), 34);
    chk("divu_z_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu_z_hi", bus.hi, 32'd5);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    chk("div_z_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div_z_hi", bus.hi, 32'hFFFF_FFF9);

    issue(OP_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mthi_hi", bus.hi, 32'h1234);
    chk("mthi_busy", W'(bus.busy), 0);
    chk("mthi_done", W'(bus.done), 0);

    issue(OP_MTLO, 32'hABCD, 32'd0);
    @(negedge clk);
    chk("mtlo_lo", bus.lo, 32'hABCD);
    chk("mtlo_hi_kept", bus.hi, 32'h1234);

    issue(3'b110, 32'h5555, 32'h6666);
    @(negedge clk);
    chk("nop_busy", W'(bus.busy), 0);
    chk("nop_hi", bus.hi, 32'h1234);
    chk("nop_lo", bus.lo, 32'hABCD);

    // Start pulses (MULTU and MTHI) with fresh operands while busy: ignored.
    issue(OP_MULTU, 32'd3, 32'd4);
    lat     = 1;
    hold_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i < 20) begin
        bus.start = i[0];
        bus.op    = i[1] ? OP_MTHI : OP_MULTU;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) break;
      if (bus.hi !== 32'h1234) hold_ok = 1'b0;
      tick();
      lat++;
    end
    bus.start = 1'b0;
    chk("busy_ign_lat", W'(lat), 34);
    chk("busy_ign_hi_hold", W'(hold_ok), 1);
    chk("busy_ign_hi", bus.hi, 32'h0);
    chk("busy_ign_lo", bus.lo, 32'd12);

    // Reset in the middle of a multiply.
    issue(OP_MTHI, 32'hBEEF, 32'd0);
    issue(OP_MULTU, 32'hFFFF, 32'hFFFF);
    repeat (8) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", W'(bus.busy), 0);
    chk("midrst_done", W'(bus.done), 0);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    tick();
    rst_n     = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
      tick();
    end
    chk("midrst_no_done", W'(done_seen), 0);
    chk("midrst_idle", W'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
